// File: rtl/ahb_arb_pkg.sv
// Shared transfer-type constants and index helpers for the AHB bridge arbiter.
package ahb_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam int MAX_MASTERS = 16;

   function automatic int master_id_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic logic [MAX_MASTERS-1:0] onehot_of(input logic [3:0] idx);
      return {{(MAX_MASTERS-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first request above the last owner,
// otherwise the first request overall (owner itself ends up lowest priority).
module rr_picker #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [W-1:0] winner,
   output logic         any_req
);

   logic [N-1:0] mask;
   logic [N-1:0] req_masked;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_mask
         assign mask[gi] = (gi > int'(last));
      end
   endgenerate

   assign req_masked = req & mask;
   assign any_req    = |req;

   always_comb begin
      winner = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) winner = W'(i);
      end
      if (|req_masked) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (req_masked[i]) winner = W'(i);
         end
      end
   end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB arbiter sharing the APB bridge slave port, with a beat cap.
// Define AHB_ARB_LOCK_EN to honour Hlock locked sequences.
module ahb_bridge_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS     = 4,
   parameter int DEFAULT_MASTER  = 0,
   parameter int MAX_BURST_BEATS = 16,
   localparam int MW = master_id_width(NUM_MASTERS)
) (
   input  logic                   Hclk,
   input  logic                   Hreset,
   input  logic [NUM_MASTERS-1:0] Hbusreq,
   input  logic [NUM_MASTERS-1:0] Hlock,
   input  logic [1:0]             Htrans,
   input  logic                   Hreadyout,
   output logic [NUM_MASTERS-1:0] Hgrant,
   output logic [MW-1:0]          Hmaster,
   output logic [MW-1:0]          Hmaster_data,
   output logic                   Hmastlock
);

   localparam logic [MW-1:0] DEF_ID = MW'(DEFAULT_MASTER);

   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [MW-1:0]          master_q, master_d;
   logic [MW-1:0]          master_data_q, master_data_d;
   logic                   mastlock_q, mastlock_d;
   logic [7:0]             beat_q, beat_d;

   logic [MW-1:0] rr_winner;
   logic          any_req;
   logic [MW-1:0] winner;
   logic          own_req;
   logic          lock_hold;
   logic          cap_hit;
   logic          arb_pt;

   rr_picker #(
      .N (NUM_MASTERS),
      .W (MW)
   ) u_rr_picker (
      .req     (Hbusreq),
      .last    (master_q),
      .winner  (rr_winner),
      .any_req (any_req)
   );

   assign own_req = Hbusreq[master_q];
   assign cap_hit = (beat_q >= 8'(MAX_BURST_BEATS));

`ifdef AHB_ARB_LOCK_EN
   assign lock_hold = Hlock[master_q] & own_req;
`else
   logic unused_hlock;
   assign unused_hlock = ^Hlock;
   assign lock_hold    = 1'b0;
`endif

   // SEQ is never a handover point; NONSEQ only once the tenure has used its cap.
   assign arb_pt = Hreadyout &&
                   ((Htrans == HTRANS_IDLE) ||
                    (Htrans == HTRANS_BUSY && !own_req) ||
                    (Htrans == HTRANS_NONSEQ && cap_hit && !lock_hold));

   assign winner = lock_hold ? master_q : (any_req ? rr_winner : DEF_ID);

   always_comb begin
      grant_d       = grant_q;
      master_d      = master_q;
      master_data_d = master_data_q;
      mastlock_d    = mastlock_q;
      beat_d        = beat_q;
      if (Hreadyout) begin
         master_data_d = master_q;
         if (arb_pt) begin
            grant_d  = NUM_MASTERS'(onehot_of(4'(winner)));
            master_d = winner;
            beat_d   = '0;
`ifdef AHB_ARB_LOCK_EN
            mastlock_d = Hlock[winner];
`endif
         end else if (Htrans[1] && !cap_hit) begin
            beat_d = beat_q + 8'd1;
         end
      end
   end

   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         grant_q       <= NUM_MASTERS'(onehot_of(4'(DEF_ID)));
         master_q      <= DEF_ID;
         master_data_q <= DEF_ID;
         mastlock_q    <= 1'b0;
         beat_q        <= '0;
      end else begin
         grant_q       <= grant_d;
         master_q      <= master_d;
         master_data_q <= master_data_d;
         mastlock_q    <= mastlock_d;
         beat_q        <= beat_d;
      end
   end

   assign Hgrant       = grant_q;
   assign Hmaster      = master_q;
   assign Hmaster_data = master_data_q;
   assign Hmastlock    = mastlock_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Self-checking bench for ahb_bridge_arbiter: directed scenarios plus random
// traffic compared every cycle against a tenure-level reference model.
module tb_ahb_bridge_arbiter;

   localparam int N   = 4;
   localparam int DEF = 0;
   localparam int CAP = 4;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   logic       Hclk = 1'b0;
   logic       Hreset = 1'b1;
   logic [3:0] Hbusreq = '0;
   logic [3:0] Hlock = '0;
   logic [1:0] Htrans = T_IDLE;
   logic       Hreadyout = 1'b1;
   logic [3:0] Hgrant;
   logic [1:0] Hmaster;
   logic [1:0] Hmaster_data;
   logic       Hmastlock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model state: who owns the bus, who owns the data phase,
   // completed beats in the current tenure and the lock flag.
   int m_owner = DEF;
   int m_data  = DEF;
   int m_beats = 0;
   bit m_lock  = 1'b0;

   ahb_bridge_arbiter #(
      .NUM_MASTERS     (N),
      .DEFAULT_MASTER  (DEF),
      .MAX_BURST_BEATS (CAP)
   ) dut (
      .Hclk         (Hclk),
      .Hreset       (Hreset),
      .Hbusreq      (Hbusreq),
      .Hlock        (Hlock),
      .Htrans       (Htrans),
      .Hreadyout    (Hreadyout),
      .Hgrant       (Hgrant),
      .Hmaster      (Hmaster),
      .Hmaster_data (Hmaster_data),
      .Hmastlock    (Hmastlock)
   );

   always #5 Hclk = ~Hclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rr_next(input int owner, input logic [3:0] req);
      for (int k = 1; k <= N; k++) begin
         if (req[(owner + k) % N]) return (owner + k) % N;
      end
      return DEF;
   endfunction

   task automatic model_edge();
      bit locked;
      bit arb;
      int w;
      if (Hreset) begin
         m_owner = DEF;
         m_data  = DEF;
         m_beats = 0;
         m_lock  = 1'b0;
      end else if (Hreadyout) begin
         locked = 1'b0;
`ifdef AHB_ARB_LOCK_EN
         locked = Hlock[m_owner] && Hbusreq[m_owner];
`endif
         arb = (Htrans == T_IDLE) ||
               (Htrans == T_BUSY && !Hbusreq[m_owner]) ||
               (Htrans == T_NONSEQ && m_beats >= CAP && !locked);
         m_data = m_owner;
         if (arb) begin
            w = locked ? m_owner : rr_next(m_owner, Hbusreq);
            m_owner = w;
            m_beats = 0;
`ifdef AHB_ARB_LOCK_EN
            m_lock = Hlock[w];
`endif
         end else if ((Htrans == T_NONSEQ || Htrans == T_SEQ) && m_beats < CAP) begin
            m_beats++;
         end
      end
   endtask

   task automatic step();
      @(posedge Hclk);
      model_edge();
      #1;
      cyc++;
      $display("cyc %0d rst=%b req=%b lock=%b trans=%0d rdy=%b -> grant=%b m=%0d md=%0d ml=%b",
               cyc, Hreset, Hbusreq, Hlock, Htrans, Hreadyout, Hgrant, Hmaster, Hmaster_data, Hmastlock);
      check_eq("grant",     32'(Hgrant),       32'(1) << m_owner);
      check_eq("master",    32'(Hmaster),      32'(m_owner));
      check_eq("mdata",     32'(Hmaster_data), 32'(m_data));
      check_eq("mastlock",  32'(Hmastlock),    32'(m_lock));
   endtask

   task automatic drive(input logic [3:0] req, input logic [1:0] tr, input logic rdy, input logic [3:0] lk);
      Hreset    = 1'b0;
      Hbusreq   = req;
      Htrans    = tr;
      Hreadyout = rdy;
      Hlock     = lk;
   endtask

   initial begin
      logic rdy_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

      // Reset then an idle bus parks on the default master
      Hreset = 1'b1;
      step();
      step();
      drive(4'b0000, T_IDLE, 1'b1, 4'b0000);
      repeat (5) step();
      check_eq("t1_grant", 32'(Hgrant), 32'h1);
      check_eq("t1_master", 32'(Hmaster), 32'd0);
      check_eq("t1_mdata", 32'(Hmaster_data), 32'd0);
      check_eq("t1_mastlock", 32'(Hmastlock), 32'd0);

      // Round-robin handover at IDLE, then park
      drive(4'b0110, T_IDLE, 1'b1, 4'b0000);
      step();
      check_eq("t2_first", 32'(Hmaster), 32'd1);
      step();
      check_eq("t2_second", 32'(Hmaster), 32'd2);
      drive(4'b0000, T_IDLE, 1'b1, 4'b0000);
      step();
      check_eq("t2_park", 32'(Hgrant), 32'h1);

      // SEQ burst with ready stalls holds the grant
      drive(4'b0100, T_IDLE, 1'b1, 4'b0000);
      step();
      check_eq("t3_own", 32'(Hmaster), 32'd2);
      drive(4'b1100, T_NONSEQ, 1'b1, 4'b0000);
      step();
      Htrans = T_SEQ;
      for (int i = 0; i < 4; i++) begin
         Hreadyout = rdy_seq[i];
         step();
         check_eq("t3_hold", 32'(Hmaster), 32'd2);
      end
      check_eq("t3_mdata", 32'(Hmaster_data), 32'd2);
      drive(4'b1000, T_IDLE, 1'b1, 4'b0000);
      step();
      check_eq("t3_handover", 32'(Hmaster), 32'd3);

      // Beat cap alternates two continuously requesting masters on NONSEQ
      drive(4'b0011, T_IDLE, 1'b1, 4'b0000);
      step();
      check_eq("t4_start", 32'(Hmaster), 32'd0);
      drive(4'b0011, T_NONSEQ, 1'b1, 4'b0000);
      repeat (CAP) step();
      check_eq("t4_before_cap", 32'(Hmaster), 32'd0);
      step();
      check_eq("t4_cap_to_1", 32'(Hmaster), 32'd1);
      repeat (CAP + 1) step();
      check_eq("t4_cap_to_0", 32'(Hmaster), 32'd0);

`ifdef AHB_ARB_LOCK_EN
      // Locked owner keeps the bus past the beat cap
      drive(4'b1000, T_IDLE, 1'b1, 4'b1000);
      step();
      check_eq("t5_own", 32'(Hmaster), 32'd3);
      drive(4'b1001, T_NONSEQ, 1'b1, 4'b1000);
      for (int i = 0; i < 20; i++) begin
         step();
         check_eq("t5_keep", 32'(Hmaster), 32'd3);
         check_eq("t5_lock", 32'(Hmastlock), 32'd1);
      end
      drive(4'b1001, T_IDLE, 1'b1, 4'b0000);
      step();
      check_eq("t5_release", 32'(Hmaster), 32'd0);
`endif

      // Reset mid-burst abandons the tenure and clears the beat count
      drive(4'b0100, T_IDLE, 1'b1, 4'b0000);
      step();
      check_eq("t6_own", 32'(Hmaster), 32'd2);
      drive(4'b0100, T_NONSEQ, 1'b1, 4'b0000);
      step();
      Htrans = T_SEQ;
      step();
      step();
      Hreset = 1'b1;
      step();
      check_eq("t6_grant", 32'(Hgrant), 32'h1);
      check_eq("t6_master", 32'(Hmaster), 32'd0);
      check_eq("t6_mdata", 32'(Hmaster_data), 32'd0);
      drive(4'b0101, T_NONSEQ, 1'b1, 4'b0000);
      repeat (CAP) step();
      check_eq("t6_fresh_cap", 32'(Hmaster), 32'd0);
      step();
      check_eq("t6_cap_handover", 32'(Hmaster), 32'd2);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         Hreset    = ($urandom_range(60) == 0);
         Hbusreq   = 4'($urandom);
         Htrans    = 2'($urandom);
         Hreadyout = ($urandom_range(3) != 0);
         Hlock     = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
